// File: rtl/stmask_splitter_pkg.sv
// Shared types and constants for the LSU store-beat splitter.
package stmask_splitter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND
  } state_e;

  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  function automatic int unsigned size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/stmask_splitter_if.sv
// Request/beat handshake bundle for the store splitter.
interface stmask_splitter_if #(
  parameter int unsigned WORDLEN = 64,
  parameter int unsigned ADRLEN  = 32,
  parameter int unsigned CNTW    = 16
);
  logic                   ReqValid;
  logic                   ReqReady;
  logic [2:0]             ReqSize;
  logic [ADRLEN-1:0]      ReqAdr;
  logic [WORDLEN-1:0]     ReqData;
  logic                   BeatValid;
  logic                   BeatReady;
  logic [ADRLEN-1:0]      BeatAdr;
  logic [WORDLEN/8-1:0]   BeatByteMask;
  logic [WORDLEN-1:0]     BeatData;
  logic                   BeatLast;
  logic                   BeatErr;
  logic [CNTW-1:0]        SplitCount;

  modport master (
    output ReqValid, ReqSize, ReqAdr, ReqData, BeatReady,
    input  ReqReady, BeatValid, BeatAdr, BeatByteMask, BeatData,
           BeatLast, BeatErr, SplitCount
  );

  modport slave (
    input  ReqValid, ReqSize, ReqAdr, ReqData, BeatReady,
    output ReqReady, BeatValid, BeatAdr, BeatByteMask, BeatData,
           BeatLast, BeatErr, SplitCount
  );
endinterface

// File: rtl/stmask_splitter_gen.sv
// Double-width byte mask and lane-shifted data for one store request.
module stmask_gen
  import stmask_splitter_pkg::*;
#(
  parameter int unsigned WORDLEN = 64
) (
  input  logic [2:0]                   size_i,
  input  logic [$clog2(WORDLEN/8)-1:0] ofs_i,
  input  logic [WORDLEN-1:0]           data_i,
  output logic [2*(WORDLEN/8)-1:0]     mask2_o,
  output logic [2*WORDLEN-1:0]         data2_o,
  output logic                         split_o,
  output logic                         illegal_o
);
  localparam int unsigned WB   = WORDLEN / 8;
  localparam int unsigned OFSW = $clog2(WB);

  logic [WB-1:0]      keep_mask;
  logic [WORDLEN-1:0] keep_data;

  always_comb begin
    keep_mask = '0;
    keep_data = '0;
    for (int unsigned i = 0; i < WB; i++) begin
      keep_mask[i]       = (i < size_bytes(size_i));
      keep_data[8*i +: 8] = {8{keep_mask[i]}};
    end
    illegal_o = (32'(size_i) > OFSW);
    if (illegal_o) begin
      mask2_o = '0;
      data2_o = '0;
    end else begin
      mask2_o = {{WB{1'b0}}, keep_mask} << ofs_i;
      data2_o = {{WORDLEN{1'b0}}, data_i & keep_data} << {ofs_i, 3'b000};
    end
    split_o = |mask2_o[2*WB-1:WB];
  end

endmodule

// File: rtl/stmask_splitter.sv
// Store-path beat generator: turns one store request into one or two
// word-aligned write beats with byte mask, and counts split stores.
module stmask_splitter
  import stmask_splitter_pkg::*;
#(
  parameter int unsigned WORDLEN = 64,
  parameter int unsigned ADRLEN  = 32,
  parameter int unsigned CNTW    = 16
) (
  input logic               clk,
  input logic               reset,
  stmask_splitter_if.slave  bus
);
  localparam int unsigned WB   = WORDLEN / 8;
  localparam int unsigned OFSW = $clog2(WB);

  typedef struct packed {
    logic [ADRLEN-1:0]  adr;
    logic [WB-1:0]      mask;
    logic [WORDLEN-1:0] data;
    logic               last;
    logic               err;
  } store_beat_t;

  state_e              state_q, state_d;
  store_beat_t         beat_q, beat_d;
  logic [WB-1:0]       hi_mask_q, hi_mask_d;
  logic [WORDLEN-1:0]  hi_data_q, hi_data_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic [2*WB-1:0]      mask2;
  logic [2*WORDLEN-1:0] data2;
  logic                 split;
  logic                 illegal;
  logic                 accept;
  logic                 beat_done;

  stmask_gen #(.WORDLEN(WORDLEN)) u_gen (
    .size_i   (bus.ReqSize),
    .ofs_i    (bus.ReqAdr[OFSW-1:0]),
    .data_i   (bus.ReqData),
    .mask2_o  (mask2),
    .data2_o  (data2),
    .split_o  (split),
    .illegal_o(illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q    <= '0;
      hi_mask_q <= '0;
      hi_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      beat_q    <= beat_d;
      hi_mask_q <= hi_mask_d;
      hi_data_q <= hi_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign accept    = bus.ReqValid & bus.ReqReady;
  assign beat_done = bus.BeatValid & bus.BeatReady;

  // A new request always wins the beat register, even when it coincides
  // with acceptance of the current last beat.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    hi_mask_d = hi_mask_q;
    hi_data_d = hi_data_q;
    cnt_d     = cnt_q;
    if (accept) begin
      state_d     = FIRST;
      beat_d.adr  = {bus.ReqAdr[ADRLEN-1:OFSW], {OFSW{1'b0}}};
      beat_d.mask = mask2[WB-1:0];
      beat_d.data = data2[WORDLEN-1:0];
      beat_d.last = ~split;
      beat_d.err  = illegal;
      hi_mask_d   = mask2[2*WB-1:WB];
      hi_data_d   = data2[2*WORDLEN-1:WORDLEN];
      if (split && (cnt_q != '1)) cnt_d = cnt_q + CNTW'(1);
    end else if (beat_done) begin
      if ((state_q == FIRST) && !beat_q.last) begin
        state_d     = SECOND;
        beat_d.adr  = beat_q.adr + ADRLEN'(WB);
        beat_d.mask = hi_mask_q;
        beat_d.data = hi_data_q;
        beat_d.last = 1'b1;
        beat_d.err  = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    bus.BeatValid    = (state_q != IDLE);
    bus.ReqReady     = ~reset & ((state_q == IDLE) | (bus.BeatReady & beat_q.last));
    bus.BeatAdr      = beat_q.adr;
    bus.BeatByteMask = beat_q.mask;
    bus.BeatData     = beat_q.data;
    bus.BeatLast     = beat_q.last;
    bus.BeatErr      = beat_q.err;
    bus.SplitCount   = cnt_q;
  end

endmodule

// File: tb/tb_stmask_splitter.sv
// Randomized + directed bench for stmask_splitter at WORDLEN 64 and 32.
module tb_stmask_splitter;
  import stmask_splitter_pkg::*;

  typedef struct {
    logic [31:0] adr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        last;
    logic        err;
  } tbeat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rv [2];
  logic [2:0]  rs [2];
  logic [31:0] ra [2];
  logic [63:0] rd [2];
  logic        br [2];
  logic        rr [2];
  logic        bv [2];
  logic        bl [2];
  logic        be [2];
  logic [31:0] ba [2];
  logic [7:0]  bm [2];
  logic [63:0] bd [2];
  logic [15:0] sc [2];

  stmask_splitter_if #(.WORDLEN(64), .ADRLEN(32), .CNTW(16)) if64 ();
  stmask_splitter_if #(.WORDLEN(32), .ADRLEN(32), .CNTW(3))  if32 ();

  stmask_splitter #(.WORDLEN(64), .ADRLEN(32), .CNTW(16)) u64 (.clk(clk), .reset(reset), .bus(if64));
  stmask_splitter #(.WORDLEN(32), .ADRLEN(32), .CNTW(3))  u32 (.clk(clk), .reset(reset), .bus(if32));

  assign if64.ReqValid = rv[0];
  assign if64.ReqSize  = rs[0];
  assign if64.ReqAdr   = ra[0];
  assign if64.ReqData  = rd[0];
  assign if64.BeatReady = br[0];
  assign if32.ReqValid = rv[1];
  assign if32.ReqSize  = rs[1];
  assign if32.ReqAdr   = ra[1];
  assign if32.ReqData  = rd[1][31:0];
  assign if32.BeatReady = br[1];

  assign rr[0] = if64.ReqReady;
  assign bv[0] = if64.BeatValid;
  assign bl[0] = if64.BeatLast;
  assign be[0] = if64.BeatErr;
  assign ba[0] = if64.BeatAdr;
  assign bm[0] = if64.BeatByteMask;
  assign bd[0] = if64.BeatData;
  assign sc[0] = if64.SplitCount;
  assign rr[1] = if32.ReqReady;
  assign bv[1] = if32.BeatValid;
  assign bl[1] = if32.BeatLast;
  assign be[1] = if32.BeatErr;
  assign ba[1] = if32.BeatAdr;
  assign bm[1] = {4'b0, if32.BeatByteMask};
  assign bd[1] = {32'b0, if32.BeatData};
  assign sc[1] = {13'b0, if32.SplitCount};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: place each store byte by its absolute address.
  function automatic int model(input int unsigned wb, input int unsigned lg,
                               input logic [2:0] size, input logic [31:0] adr,
                               input logic [63:0] data,
                               output tbeat_t b0, output tbeat_t b1);
    logic [31:0] base, a, rel;
    int unsigned nb, lane;
    base = adr & ~(wb - 1);
    b0.adr = base;      b0.mask = '0; b0.data = '0; b0.last = 1'b1; b0.err = 1'b0;
    b1.adr = base + wb; b1.mask = '0; b1.data = '0; b1.last = 1'b1; b1.err = 1'b0;
    if (int'(size) > int'(lg)) begin
      b0.err = 1'b1;
      return 1;
    end
    nb = 1 << size;
    for (int unsigned i = 0; i < nb; i++) begin
      a    = adr + i;
      rel  = a - base;
      lane = a % wb;
      if (rel < wb) begin
        b0.mask[lane] = 1'b1;
        b0.data[8*lane +: 8] = data[8*i +: 8];
      end else begin
        b1.mask[lane] = 1'b1;
        b1.data[8*lane +: 8] = data[8*i +: 8];
      end
    end
    if (b1.mask != '0) begin
      b0.last = 1'b0;
      return 2;
    end
    return 1;
  endfunction

  tbeat_t q0[$];
  tbeat_t q1[$];
  logic [15:0] cnt [2];

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic tbeat_t qfront(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void qpush(input int d, input tbeat_t b);
    if (d == 0) q0.push_back(b);
    else        q1.push_back(b);
  endfunction

  function automatic void qpop(input int d);
    tbeat_t t;
    if (d == 0) t = q0.pop_front();
    else        t = q1.pop_front();
  endfunction

  task automatic step(input int d);
    tbeat_t f, b0, b1;
    int     n;
    logic   ev;
    logic [15:0] cmax;
    cmax = (d == 0) ? 16'hFFFF : 16'h0007;
    if (reset) begin
      chk($sformatf("rst_valid_d%0d", d), 128'(bv[d]), 128'(0));
      chk($sformatf("rst_count_d%0d", d), 128'(sc[d]), 128'(0));
      if (d == 0) q0.delete();
      else        q1.delete();
      cnt[d] = '0;
      return;
    end
    ev = (qsize(d) != 0);
    f.adr = '0; f.mask = '0; f.data = '0; f.last = 1'b0; f.err = 1'b0;
    if (ev) f = qfront(d);
    chk($sformatf("beat_valid_d%0d", d), 128'(bv[d]), 128'(ev));
    if (ev)
      chk($sformatf("beat_d%0d", d), {ba[d], bm[d], bd[d], bl[d], be[d]},
          {f.adr, f.mask, f.data, f.last, f.err});
    chk($sformatf("req_ready_d%0d", d), 128'(rr[d]), 128'(ev ? (br[d] && f.last) : 1'b1));
    chk($sformatf("split_count_d%0d", d), 128'(sc[d]), 128'(cnt[d]));
    if (bv[d] && br[d] && ev) qpop(d);
    if (rv[d] && rr[d]) begin
      if (d == 0) n = model(8, 3, rs[d], ra[d], rd[d], b0, b1);
      else        n = model(4, 2, rs[d], ra[d], rd[d], b0, b1);
      qpush(d, b0);
      if (n == 2) begin
        qpush(d, b1);
        if (cnt[d] != cmax) cnt[d] = cnt[d] + 16'd1;
      end
    end
  endtask

  always @(negedge clk) begin
    step(0);
    step(1);
  end

  task automatic send(input int d, input logic [2:0] size, input logic [31:0] adr,
                      input logic [63:0] data);
    logic got;
    got = 1'b0;
    rv[d] = 1'b1; rs[d] = size; ra[d] = adr; rd[d] = data;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (rr[d]) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    rv[d] = 1'b0;
    if (!got) chk("send_timeout", 128'(got), 128'(1));
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic rand_phase(input int d, input int cycles);
    logic acc;
    rv[d] = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      acc = rv[d] && rr[d];
      @(posedge clk); #1;
      if (acc || !rv[d]) begin
        rv[d] = ($urandom_range(0, 3) != 0);
        rs[d] = 3'($urandom_range(0, (d == 0) ? 4 : 3));
        ra[d] = $urandom;
        if ($urandom_range(0, 7) == 0) ra[d] = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
        rd[d] = {$urandom, $urandom};
      end
      br[d] = ($urandom_range(0, 3) != 0);
    end
    rv[d] = 1'b0;
    br[d] = 1'b1;
    repeat (6) next_cyc();
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rv[d] = 1'b0; rs[d] = '0; ra[d] = '0; rd[d] = '0; br[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_valid", 128'(bv[0]), 128'(0));
    chk("reset_ready", 128'(rr[0]), 128'(1));
    chk("reset_count", 128'(sc[0]), 128'(0));
    next_cyc();

    // aligned doubleword
    send(0, SIZE_D, 32'h1000, 64'h1122_3344_5566_7788);
    chk("sd_adr",  128'(ba[0]), 128'(32'h1000));
    chk("sd_mask", 128'(bm[0]), 128'(8'hFF));
    chk("sd_data", 128'(bd[0]), 128'(64'h1122_3344_5566_7788));
    chk("sd_last", 128'(bl[0]), 128'(1));
    next_cyc();
    chk("sd_count", 128'(sc[0]), 128'(0));

    // misaligned word crossing the boundary
    send(0, SIZE_W, 32'h1006, 64'hAABB_CCDD);
    chk("sw_b0", {ba[0], bm[0], bd[0], bl[0]}, {32'h1000, 8'hC0, 64'hCCDD_0000_0000_0000, 1'b0});
    next_cyc();
    chk("sw_b1", {ba[0], bm[0], bd[0], bl[0]}, {32'h1008, 8'h03, 64'h0000_0000_0000_AABB, 1'b1});
    chk("sw_count", 128'(sc[0]), 128'(1));
    next_cyc();

    // same store with consumer stalls on each beat
    br[0] = 1'b0;
    send(0, SIZE_W, 32'h1006, 64'hAABB_CCDD);
    repeat (3) next_cyc();
    chk("stall_b0", {bv[0], bm[0], bl[0], rr[0]}, {1'b1, 8'hC0, 1'b0, 1'b0});
    br[0] = 1'b1;
    next_cyc();
    br[0] = 1'b0;
    repeat (3) next_cyc();
    chk("stall_b1", {bv[0], ba[0], bm[0], bl[0], rr[0]}, {1'b1, 32'h1008, 8'h03, 1'b1, 1'b0});
    br[0] = 1'b1;
    next_cyc();
    chk("stall_done", {bv[0], sc[0]}, {1'b0, 16'd2});

    // back-to-back byte then halfword, no bubble
    rv[0] = 1'b1; rs[0] = SIZE_B; ra[0] = 32'h2003; rd[0] = 64'h5A;
    next_cyc();
    rs[0] = SIZE_H; ra[0] = 32'h2004; rd[0] = 64'hBEEF;
    chk("b2b_first", {bv[0], bm[0], bd[0]}, {1'b1, 8'h08, 64'h5A00_0000});
    next_cyc();
    rv[0] = 1'b0;
    chk("b2b_second", {bv[0], bm[0], bd[0]}, {1'b1, 8'h30, 64'hBEEF_0000_0000});
    next_cyc();

    // reset while the second beat is presented
    send(0, SIZE_W, 32'h1006, 64'hAABB_CCDD);
    next_cyc();
    br[0] = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_valid", 128'(bv[0]), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    br[0] = 1'b1;
    next_cyc();
    send(0, SIZE_D, 32'h3000, 64'h0102_0304_0506_0708);
    chk("postrst_sd", {ba[0], bm[0], bl[0], be[0]}, {32'h3000, 8'hFF, 1'b1, 1'b0});
    chk("postrst_cnt", 128'(sc[0]), 128'(0));
    next_cyc();

    // 32-bit bus: illegal doubleword, then halfword wrapping the address space
    send(1, SIZE_D, 32'h0000_0100, 64'h1122_3344_5566_7788);
    chk("w32_illegal", {bm[1], bd[1], be[1], bl[1]}, {8'h0, 64'h0, 1'b1, 1'b1});
    next_cyc();
    send(1, SIZE_H, 32'hFFFF_FFFF, 64'h1234);
    chk("w32_wrap_b0", {ba[1], bm[1], bd[1], bl[1]}, {32'hFFFF_FFFC, 8'h08, 64'h3400_0000, 1'b0});
    next_cyc();
    chk("w32_wrap_b1", {ba[1], bm[1], bd[1], bl[1]}, {32'h0000_0000, 8'h01, 64'h12, 1'b1});
    next_cyc();

    rand_phase(0, 600);
    rand_phase(1, 600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

endmodule
